// File: rtl/doodle_motion_engine.sv
// Doodle player physics and sprite addressing: fixed-point jump integrator, horizontal
// wrap, scroll-line clamp, death detection and optionally mirrored texture lookup.
module doodle_motion_engine #(
    parameter int SPRITE_W    = 80,
    parameter int SPRITE_H    = 80,
    parameter int X_MIN       = 300,
    parameter int X_MAX       = 642,
    parameter int START_X     = 472,
    parameter int START_Y     = 687,
    parameter int FRAC        = 4,
    parameter int JUMP_VEL    = 144,
    parameter int BOOST_VEL   = 288,
    parameter int GRAVITY     = 3,
    parameter int MAX_FALL    = 192,
    parameter int SCROLL_LINE = 300,
    parameter int SCREEN_H    = 768,
    parameter int MIRROR      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_tick,
    input  logic [1:0]                  game_state,
    input  logic signed [8:0]           delta_x,
    input  logic                        land,
    input  logic [9:0]                  land_y,
    input  logic                        spring,
    input  logic [10:0]                 beam_x,
    input  logic [9:0]                  beam_y,
    output logic [10:0]                 doodle_x,
    output logic [9:0]                  doodle_y,
    output logic                        doodle_fall_direction,
    output logic                        facing_left,
    output logic [9:0]                  scroll_dy,
    output logic                        scroll_valid,
    output logic                        dead,
    output logic                        in_sprite,
    output logic [$clog2(SPRITE_H)-1:0] sprite_row,
    output logic [$clog2(SPRITE_W)-1:0] sprite_col
);
    localparam int YW = 10 + FRAC + 2;
    localparam int RW = $clog2(SPRITE_H);
    localparam int CW = $clog2(SPRITE_W);

    localparam logic signed [11:0] X_MIN_S = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] SPAN_S  = 12'(X_MAX - X_MIN);
    localparam logic signed [11:0] SPR_W_S = 12'(SPRITE_W);
    localparam logic signed [10:0] SPR_H_S = 11'(SPRITE_H);

    localparam logic signed [YW-1:0] START_Y_Q = YW'(START_Y << FRAC);
    localparam logic signed [YW-1:0] SCROLL_Q  = YW'(SCROLL_LINE << FRAC);
    localparam logic signed [YW-1:0] SCROLL_I  = YW'(SCROLL_LINE);
    localparam logic signed [YW-1:0] SCREEN_I  = YW'(SCREEN_H);
    localparam logic signed [YW-1:0] JUMP_Q    = YW'(JUMP_VEL);
    localparam logic signed [YW-1:0] BOOST_Q   = YW'(BOOST_VEL);
    localparam logic signed [YW-1:0] GRAV_Q    = YW'(GRAVITY);
    localparam logic signed [YW-1:0] FALL_LIM  = YW'(-MAX_FALL);
    localparam logic signed [YW-1:0] LAND_OFS  = YW'(SPRITE_H + 1);
    localparam logic signed [YW-1:0] ZERO_Q    = '0;
    localparam logic [10:0]          START_X_U = 11'(START_X);
    localparam logic [CW-1:0]        COL_LAST  = CW'(SPRITE_W - 1);

    // A single correction suffices because |delta_x| never exceeds the playfield span.
    function automatic logic [10:0] wrap_x(input logic signed [11:0] xt);
        logic signed [11:0] r;
        if (xt < X_MIN_S)
            r = xt + SPAN_S;
        else if (xt >= X_MAX_S)
            r = xt - SPAN_S;
        else
            r = xt;
        return 11'(r);
    endfunction

    function automatic logic signed [YW-1:0] sat_fall(input logic signed [YW-1:0] v);
        return (v < FALL_LIM) ? FALL_LIM : v;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RISE, S_FALL, S_DEAD} state_t;
    state_t state, state_next;

    logic [10:0]          x;
    logic signed [YW-1:0] y;
    logic signed [YW-1:0] vel;
    logic [9:0]           y_int;
    logic signed [11:0]   x_sum;
    logic [10:0]          x_wrap;
    logic signed [YW-1:0] y_next;
    logic signed [YW-1:0] vel_next;
    logic signed [YW-1:0] y_next_int;
    logic signed [YW-1:0] land_top;
    logic                 menu;
    logic                 frozen;
    logic                 takeoff;
    logic                 phys_tick;
    logic                 x_tick;
    logic                 clamp;
    logic                 landing;
    logic                 dying;

    assign y_int    = y[FRAC+9:FRAC];
    assign doodle_x = x;
    assign doodle_y = y_int;

    always_comb begin
        menu       = (game_state == 2'd0);
        frozen     = (game_state == 2'd2);
        takeoff    = (state == S_IDLE) && frame_tick && (game_state == 2'd1);
        phys_tick  = frame_tick && !menu && !frozen && (state == S_RISE || state == S_FALL);
        x_tick     = phys_tick || (frame_tick && !menu && state == S_DEAD);
        x_sum      = $signed({1'b0, x}) + $signed({{3{delta_x[8]}}, delta_x});
        x_wrap     = wrap_x(x_sum);
        y_next     = y - vel;
        vel_next   = sat_fall(vel - GRAV_Q);
        y_next_int = y_next >>> FRAC;
        land_top   = ($signed({{(YW-10){1'b0}}, land_y}) - LAND_OFS) <<< FRAC;
        clamp      = phys_tick && (state == S_RISE) && (y_next_int < SCROLL_I);
        landing    = phys_tick && (state == S_FALL) && land;
        dying      = phys_tick && (state == S_FALL) && !land && (y_next_int >= SCREEN_I);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Menu overrides every state; landing wins over death on the same tick.
    always_comb begin
        state_next = state;
        if (menu) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (takeoff) state_next = S_RISE;
                S_RISE:  if (phys_tick && vel_next <= ZERO_Q) state_next = S_FALL;
                S_FALL: begin
                    if (landing)
                        state_next = S_RISE;
                    else if (dying)
                        state_next = S_DEAD;
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        doodle_fall_direction = (state == S_FALL);
    end

    // Motion stage: position, velocity, facing, death and scroll outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x            <= START_X_U;
            y            <= START_Y_Q;
            vel          <= ZERO_Q;
            facing_left  <= 1'b0;
            dead         <= 1'b0;
            scroll_dy    <= '0;
            scroll_valid <= 1'b0;
        end else begin
            scroll_valid <= 1'b0;
            if (menu) begin
                x    <= START_X_U;
                y    <= START_Y_Q;
                vel  <= ZERO_Q;
                dead <= 1'b0;
            end else begin
                if (takeoff)
                    vel <= JUMP_Q;
                if (x_tick) begin
                    x <= x_wrap;
                    if (delta_x[8])
                        facing_left <= 1'b1;
                    else if (delta_x != 9'sd0)
                        facing_left <= 1'b0;
                end
                if (landing) begin
                    y   <= land_top;
                    vel <= spring ? BOOST_Q : JUMP_Q;
                end else if (dying) begin
                    dead <= 1'b1;
                end else if (phys_tick) begin
                    vel <= vel_next;
                    if (clamp) begin
                        y            <= SCROLL_Q;
                        scroll_dy    <= 10'(SCROLL_I - y_next_int);
                        scroll_valid <= 1'b1;
                    end else begin
                        y <= y_next;
                    end
                end
            end
        end
    end

    logic signed [11:0] beam_dx;
    logic signed [10:0] beam_dy;
    logic               hit;
    logic [RW-1:0]      row_calc;
    logic [CW-1:0]      col_calc;
    logic               hit_p1;
    logic [RW-1:0]      row_p1;
    logic [CW-1:0]      col_p1;

    always_comb begin
        beam_dx  = $signed({1'b0, beam_x}) - $signed({1'b0, x});
        beam_dy  = $signed({1'b0, beam_y}) - $signed({1'b0, y_int});
        hit      = (beam_dx >= 12'sd0) && (beam_dx < SPR_W_S) &&
                   (beam_dy >= 11'sd0) && (beam_dy < SPR_H_S);
        row_calc = '0;
        col_calc = '0;
        if (hit) begin
            row_calc = beam_dy[RW-1:0];
            col_calc = ((MIRROR != 0) && facing_left) ? COL_LAST - beam_dx[CW-1:0]
                                                      : beam_dx[CW-1:0];
        end
    end

    // Sprite stage p1: beam hit test registered against the current position
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_p1 <= 1'b0;
            row_p1 <= '0;
            col_p1 <= '0;
        end else begin
            hit_p1 <= hit;
            row_p1 <= row_calc;
            col_p1 <= col_calc;
        end
    end

    assign in_sprite  = hit_p1;
    assign sprite_row = row_p1;
    assign sprite_col = col_p1;

endmodule

// File: tb/tb_doodle_motion_engine.sv
// Bench for doodle_motion_engine: directed scenarios plus a randomized run checked
// against an integer-arithmetic reference model of the player physics.
`timescale 1ns/1ps
module tb_doodle_motion_engine;
    localparam int M_IDLE = 0;
    localparam int M_RISE = 1;
    localparam int M_FALL = 2;
    localparam int M_DEAD = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_tick;
    logic [1:0]        game_state;
    logic signed [8:0] delta_x;
    logic              land;
    logic [9:0]        land_y;
    logic              spring;
    logic [10:0]       beam_x;
    logic [9:0]        beam_y;
    logic [10:0]       doodle_x;
    logic [9:0]        doodle_y;
    logic              doodle_fall_direction;
    logic              facing_left;
    logic [9:0]        scroll_dy;
    logic              scroll_valid;
    logic              dead;
    logic              in_sprite;
    logic [6:0]        sprite_row;
    logic [6:0]        sprite_col;

    int n_tests = 0;
    int n_fail  = 0;

    int m_state, m_x, m_y, m_vel, m_sdy, e_row, e_col;
    bit m_face, m_dead, m_sv, e_in;

    always #5 clk = ~clk;

    doodle_motion_engine dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_state(game_state),
        .delta_x(delta_x), .land(land), .land_y(land_y), .spring(spring),
        .beam_x(beam_x), .beam_y(beam_y), .doodle_x(doodle_x), .doodle_y(doodle_y),
        .doodle_fall_direction(doodle_fall_direction), .facing_left(facing_left),
        .scroll_dy(scroll_dy), .scroll_valid(scroll_valid), .dead(dead),
        .in_sprite(in_sprite), .sprite_row(sprite_row), .sprite_col(sprite_col)
    );

    function automatic void model_reset();
        m_state = M_IDLE; m_x = 472; m_y = 687 * 16; m_vel = 0;
        m_face = 0; m_dead = 0; m_sv = 0; m_sdy = 0;
        e_in = 0; e_row = 0; e_col = 0;
    endfunction

    // One clock of the reference model, using the inputs present at the edge.
    function automatic void model_step();
        int dx, dy, yn, vn, xt;
        if (!rst) begin
            model_reset();
            return;
        end
        dx = int'(beam_x) - m_x;
        dy = int'(beam_y) - (m_y >>> 4);
        if (dx >= 0 && dx < 80 && dy >= 0 && dy < 80) begin
            e_in = 1; e_row = dy; e_col = m_face ? 79 - dx : dx;
        end else begin
            e_in = 0; e_row = 0; e_col = 0;
        end
        m_sv = 0;
        if (game_state == 2'd0) begin
            m_state = M_IDLE; m_x = 472; m_y = 687 * 16; m_vel = 0; m_dead = 0;
            return;
        end
        if (!frame_tick) return;
        if (m_state == M_IDLE) begin
            if (game_state == 2'd1) begin m_state = M_RISE; m_vel = 144; end
            return;
        end
        if (m_state != M_DEAD && game_state == 2'd2) return;
        xt = m_x + int'(delta_x);
        if (xt < 300) xt += 342;
        else if (xt >= 642) xt -= 342;
        m_x = xt;
        if (delta_x < 0) m_face = 1;
        else if (delta_x > 0) m_face = 0;
        if (m_state == M_DEAD) return;
        yn = m_y - m_vel;
        vn = (m_vel - 3 < -192) ? -192 : m_vel - 3;
        if (m_state == M_RISE) begin
            m_vel = vn;
            if ((yn >>> 4) < 300) begin
                m_y = 300 * 16; m_sdy = 300 - (yn >>> 4); m_sv = 1;
            end else begin
                m_y = yn;
            end
            if (vn <= 0) m_state = M_FALL;
        end else if (land) begin
            m_y = (int'(land_y) - 81) * 16;
            m_vel = spring ? 288 : 144;
            m_state = M_RISE;
        end else if ((yn >>> 4) >= 768) begin
            m_state = M_DEAD; m_dead = 1;
        end else begin
            m_y = yn; m_vel = vn;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; frame_tick = 1'b0; game_state = 2'd0; delta_x = '0; land = 1'b0;
        land_y = '0; spring = 1'b0; beam_x = '0; beam_y = '0;
        model_reset();
        repeat (2) step();
        n_tests++; if (doodle_x !== 11'd472) begin n_fail++; $display("FAIL reset_x: got %0d expected 472", doodle_x); end
        n_tests++; if (doodle_y !== 10'd687) begin n_fail++; $display("FAIL reset_y: got %0d expected 687", doodle_y); end
        n_tests++; if (doodle_fall_direction !== 1'b0) begin n_fail++; $display("FAIL reset_fall: got %0b expected 0", doodle_fall_direction); end
        n_tests++; if (facing_left !== 1'b0) begin n_fail++; $display("FAIL reset_facing: got %0b expected 0", facing_left); end
        n_tests++; if (dead !== 1'b0) begin n_fail++; $display("FAIL reset_dead: got %0b expected 0", dead); end
        n_tests++; if (scroll_valid !== 1'b0 || scroll_dy !== 10'd0) begin n_fail++; $display("FAIL reset_scroll: got %0b/%0d expected 0/0", scroll_valid, scroll_dy); end
        n_tests++; if (in_sprite !== 1'b0 || sprite_row !== 7'd0 || sprite_col !== 7'd0) begin n_fail++; $display("FAIL reset_sprite: got %0b/%0d/%0d expected 0/0/0", in_sprite, sprite_row, sprite_col); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_takeoff();
        int cnt;
        game_state = 2'd1;
        frame();
        n_tests++; if (doodle_y !== 10'd687 || doodle_fall_direction !== 1'b0) begin n_fail++; $display("FAIL takeoff_hold: got y=%0d fall=%0b expected y=687 fall=0", doodle_y, doodle_fall_direction); end
        frame();
        n_tests++; if (doodle_y !== 10'd678) begin n_fail++; $display("FAIL first_step_y: got %0d expected 678", doodle_y); end
        for (int k = 2; k <= 47; k++) frame();
        n_tests++; if (doodle_fall_direction !== 1'b0) begin n_fail++; $display("FAIL apex_tick47: got fall=%0b expected 0", doodle_fall_direction); end
        n_tests++; if (doodle_y !== 10'(m_y >>> 4)) begin n_fail++; $display("FAIL rise_path_y: got %0d expected %0d", doodle_y, m_y >>> 4); end
        frame();
        n_tests++; if (doodle_fall_direction !== 1'b1) begin n_fail++; $display("FAIL apex_tick48: got fall=%0b expected 1", doodle_fall_direction); end
        land = 1'b1; land_y = 10'd700;
        frame();
        land = 1'b0;
        n_tests++; if (doodle_y !== 10'd619 || doodle_fall_direction !== 1'b0) begin n_fail++; $display("FAIL land_y: got y=%0d fall=%0b expected y=619 fall=0", doodle_y, doodle_fall_direction); end
        frame();
        n_tests++; if (doodle_y !== 10'd610) begin n_fail++; $display("FAIL jump_vel_after_land: got %0d expected 610", doodle_y); end
        cnt = 0;
        while (doodle_fall_direction !== 1'b1 && cnt < 200) begin frame(); cnt++; end
        n_tests++; if (doodle_fall_direction !== 1'b1) begin n_fail++; $display("FAIL reach_fall_again: got fall=%0b expected 1", doodle_fall_direction); end
        land = 1'b1; spring = 1'b1; land_y = 10'd700;
        frame();
        land = 1'b0; spring = 1'b0;
        frame();
        n_tests++; if (doodle_y !== 10'd601) begin n_fail++; $display("FAIL spring_boost_y: got %0d expected 601", doodle_y); end
    endtask

    task automatic test_wrap();
        int dxs[5];
        int xs[5];
        bit fs[5];
        dxs = '{168, 5, -1, -4, 0};
        xs  = '{640, 303, 302, 640, 640};
        fs  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            delta_x = 9'(dxs[i]);
            frame();
            n_tests++; if (doodle_x !== 11'(xs[i])) begin n_fail++; $display("FAIL wrap_x[%0d]: got %0d expected %0d", i, doodle_x, xs[i]); end
            n_tests++; if (facing_left !== fs[i]) begin n_fail++; $display("FAIL facing[%0d]: got %0b expected %0b", i, facing_left, fs[i]); end
        end
        delta_x = '0;
    endtask

    task automatic test_scroll();
        int cnt = 0;
        while (doodle_fall_direction !== 1'b1 && cnt < 300) begin frame(); cnt++; end
        n_tests++; if (doodle_fall_direction !== 1'b1) begin n_fail++; $display("FAIL scroll_setup_fall: got fall=%0b expected 1", doodle_fall_direction); end
        land = 1'b1; land_y = 10'd386;
        frame();
        land = 1'b0;
        n_tests++; if (doodle_y !== 10'd305) begin n_fail++; $display("FAIL scroll_setup_y: got %0d expected 305", doodle_y); end
        step();
        n_tests++; if (scroll_valid !== 1'b0) begin n_fail++; $display("FAIL scroll_valid_before: got %0b expected 0", scroll_valid); end
        frame();
        n_tests++; if (doodle_y !== 10'd300) begin n_fail++; $display("FAIL scroll_clamp_y: got %0d expected 300", doodle_y); end
        n_tests++; if (scroll_valid !== 1'b1 || scroll_dy !== 10'd4) begin n_fail++; $display("FAIL scroll_pulse: got valid=%0b dy=%0d expected valid=1 dy=4", scroll_valid, scroll_dy); end
        step();
        n_tests++; if (scroll_valid !== 1'b0) begin n_fail++; $display("FAIL scroll_valid_width: got %0b expected 0", scroll_valid); end
    endtask

    task automatic test_death();
        int cnt = 0;
        logic [9:0] y_frozen;
        while (dead !== 1'b1 && cnt < 600) begin frame(); cnt++; end
        n_tests++; if (dead !== 1'b1) begin n_fail++; $display("FAIL death_reached: got dead=%0b expected 1", dead); end
        n_tests++; if (doodle_y !== 10'(m_y >>> 4) || doodle_y >= 10'd768) begin n_fail++; $display("FAIL death_y: got %0d expected %0d", doodle_y, m_y >>> 4); end
        n_tests++; if (doodle_fall_direction !== 1'b0) begin n_fail++; $display("FAIL death_fall_dir: got %0b expected 0", doodle_fall_direction); end
        y_frozen = doodle_y;
        delta_x = 9'sd7;
        repeat (3) frame();
        delta_x = '0;
        n_tests++; if (doodle_y !== y_frozen || dead !== 1'b1) begin n_fail++; $display("FAIL death_frozen: got y=%0d dead=%0b expected y=%0d dead=1", doodle_y, dead, y_frozen); end
        n_tests++; if (doodle_x !== 11'(m_x)) begin n_fail++; $display("FAIL death_x_moves: got %0d expected %0d", doodle_x, m_x); end
        game_state = 2'd0;
        step();
        n_tests++; if (doodle_x !== 11'd472 || doodle_y !== 10'd687 || dead !== 1'b0) begin n_fail++; $display("FAIL menu_reinit: got x=%0d y=%0d dead=%0b expected 472/687/0", doodle_x, doodle_y, dead); end
    endtask

    task automatic test_async_reset();
        int cnt = 0;
        game_state = 2'd1;
        frame();
        delta_x = -9'sd3;
        while (doodle_fall_direction !== 1'b1 && cnt < 200) begin frame(); cnt++; end
        repeat (3) frame();
        n_tests++; if (doodle_fall_direction !== 1'b1 || facing_left !== 1'b1) begin n_fail++; $display("FAIL arst_setup: got fall=%0b face=%0b expected 1/1", doodle_fall_direction, facing_left); end
        step();
        #1 rst = 1'b0;
        model_reset();
        #1;
        n_tests++; if (doodle_x !== 11'd472 || doodle_y !== 10'd687 || facing_left !== 1'b0 || doodle_fall_direction !== 1'b0) begin n_fail++; $display("FAIL async_reset: got x=%0d y=%0d face=%0b fall=%0b expected 472/687/0/0", doodle_x, doodle_y, facing_left, doodle_fall_direction); end
        delta_x = '0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_sprite();
        game_state = 2'd1;
        frame();
        delta_x = -9'sd1;
        frame();
        delta_x = '0;
        game_state = 2'd0;
        step();
        game_state = 2'd1;
        n_tests++; if (doodle_x !== 11'd472 || doodle_y !== 10'd687 || facing_left !== 1'b1) begin n_fail++; $display("FAIL sprite_setup: got x=%0d y=%0d face=%0b expected 472/687/1", doodle_x, doodle_y, facing_left); end
        beam_x = 11'd472; beam_y = 10'd687;
        step();
        n_tests++; if (in_sprite !== 1'b1 || sprite_row !== 7'd0 || sprite_col !== 7'd79) begin n_fail++; $display("FAIL sprite_corner: got %0b/%0d/%0d expected 1/0/79", in_sprite, sprite_row, sprite_col); end
        beam_x = 11'd552;
        step();
        n_tests++; if (in_sprite !== 1'b0 || sprite_row !== 7'd0 || sprite_col !== 7'd0) begin n_fail++; $display("FAIL sprite_right_edge: got %0b/%0d/%0d expected 0/0/0", in_sprite, sprite_row, sprite_col); end
        beam_x = 11'd551; beam_y = 10'd766;
        step();
        n_tests++; if (in_sprite !== 1'b1 || sprite_row !== 7'd79 || sprite_col !== 7'd0) begin n_fail++; $display("FAIL sprite_far_corner: got %0b/%0d/%0d expected 1/79/0", in_sprite, sprite_row, sprite_col); end
        beam_x = 11'd471;
        step();
        n_tests++; if (in_sprite !== 1'b0) begin n_fail++; $display("FAIL sprite_left_edge: got %0b expected 0", in_sprite); end
        beam_x = 11'd500; beam_y = 10'd686;
        step();
        n_tests++; if (in_sprite !== 1'b0) begin n_fail++; $display("FAIL sprite_top_edge: got %0b expected 0", in_sprite); end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            game_state = (r < 2) ? 2'd0 : ((r < 10) ? 2'd2 : 2'd1);
            frame_tick = ($urandom_range(0, 3) == 0);
            delta_x    = 9'(int'($urandom_range(0, 40)) - 20);
            land       = ($urandom_range(0, 7) == 0);
            land_y     = 10'($urandom_range(200, 767));
            spring     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                beam_x = 11'($urandom_range(0, 2047));
                beam_y = 10'($urandom_range(0, 1023));
            end else begin
                beam_x = 11'(m_x + int'($urandom_range(0, 100)) - 10);
                beam_y = 10'((m_y >>> 4) + int'($urandom_range(0, 100)) - 10);
            end
            step();
            n_tests++; if (doodle_x !== 11'(m_x)) begin n_fail++; $display("FAIL rnd_x @%0d: got %0d expected %0d", i, doodle_x, m_x); end
            n_tests++; if (doodle_y !== 10'(m_y >>> 4)) begin n_fail++; $display("FAIL rnd_y @%0d: got %0d expected %0d", i, doodle_y, m_y >>> 4); end
            n_tests++; if (doodle_fall_direction !== (m_state == M_FALL)) begin n_fail++; $display("FAIL rnd_fall @%0d: got %0b expected %0b", i, doodle_fall_direction, m_state == M_FALL); end
            n_tests++; if (facing_left !== m_face) begin n_fail++; $display("FAIL rnd_facing @%0d: got %0b expected %0b", i, facing_left, m_face); end
            n_tests++; if (dead !== m_dead) begin n_fail++; $display("FAIL rnd_dead @%0d: got %0b expected %0b", i, dead, m_dead); end
            n_tests++; if (scroll_valid !== m_sv || scroll_dy !== 10'(m_sdy)) begin n_fail++; $display("FAIL rnd_scroll @%0d: got %0b/%0d expected %0b/%0d", i, scroll_valid, scroll_dy, m_sv, m_sdy); end
            n_tests++; if (in_sprite !== e_in || sprite_row !== 7'(e_row) || sprite_col !== 7'(e_col)) begin n_fail++; $display("FAIL rnd_sprite @%0d: got %0b/%0d/%0d expected %0b/%0d/%0d", i, in_sprite, sprite_row, sprite_col, e_in, e_row, e_col); end
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_takeoff();
        test_wrap();
        test_scroll();
        test_death();
        test_async_reset();
        test_sprite();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/doodle_motion_engine.md
Name: doodle_motion_engine

Overview:
- Parametrised successor to the player-sprite controller, and the next-generation player physics and sprite-addressing block.
- Replaces closed-form jump arithmetic with a fixed-point velocity/gravity integrator.
- Adds spring boost, terminal velocity, scroll-line clamping with a scroll output, death detection, and mirrored single-texture addressing.
- Sits between the input/collision logic and the pixel mixer; texture ROMs stay external.

Parameters:
- SPRITE_W, 80, sprite width in px.
- SPRITE_H, 80, sprite height in px.
- X_MIN, 300, left edge of the playfield (inclusive).
- X_MAX, 642, right edge of the playfield (exclusive); SPAN = X_MAX - X_MIN.
- START_X, 472, reset/idle x.
- START_Y, 687, reset/idle y.
- FRAC, 4, fractional bits of y and velocity.
- JUMP_VEL, 144, takeoff velocity in Q.FRAC (9.0 px/frame); positive means up.
- BOOST_VEL, 288, spring takeoff velocity in Q.FRAC.
- GRAVITY, 3, velocity decrement per frame in Q.FRAC.
- MAX_FALL, 192, terminal fall speed magnitude in Q.FRAC.
- SCROLL_LINE, 300, minimum y while rising.
- SCREEN_H, 768, y at or beyond which the doodle dies.
- MIRROR, 1, 1 = mirror the column for left-facing; 0 = unmirrored, with facing_left selecting the texture externally.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame
- game_state  in  2  0 menu, 1 play, 2 over
- delta_x  in  9 signed  horizontal step per frame
- land  in  1  platform contact this frame
- land_y  in  10  top y of the contacted platform
- spring  in  1  contact is a spring (qualifies land)
- beam_x  in  11  current pixel x
- beam_y  in  10  current pixel y
- doodle_x  out  11  integer x
- doodle_y  out  10  integer y (y >> FRAC)
- doodle_fall_direction  out  1  1 in FALL
- facing_left  out  1  texture direction
- scroll_dy  out  10  px to scroll the world
- scroll_valid  out  1  one-cycle qualifier for scroll_dy
- dead  out  1  sticky death flag
- in_sprite  out  1  beam inside the sprite
- sprite_row  out  $clog2(SPRITE_H)  texture row
- sprite_col  out  $clog2(SPRITE_W)  texture column (mirrored per MIRROR)

Behaviour:
- Reset (rst=0, async):
  - state IDLE; x=START_X; y=START_Y<<FRAC; vel=0.
  - facing_left=0, dead=0, scroll_valid=0, scroll_dy=0, in_sprite=0, sprite_row=0, sprite_col=0.
- FSM states: IDLE, RISE, FALL, DEAD. game_state is evaluated before frame_tick in the same cycle.
- IDLE:
  - Position held at the start values.
  - game_state==1 with frame_tick -> RISE with vel=JUMP_VEL; no motion on that tick.
- game_state==0 in any state -> IDLE next cycle, with position, dead and vel reinitialised. This takes priority over everything else.
- Per frame_tick in RISE or FALL:
  - y_next = y - vel (signed, width 10+FRAC+2).
  - vel_next = max(vel - GRAVITY, -MAX_FALL).
- X update (all per-tick, RISE/FALL/DEAD):
  - x_t = x + delta_x, computed in 12-bit signed.
  - x_t < X_MIN -> x_t + SPAN.
  - x_t >= X_MAX -> x_t - SPAN.
  - Otherwise x_t.
- Facing, updated on every tick: delta_x<0 -> 1; delta_x>0 -> 0; delta_x==0 -> hold.
- RISE:
  - Land and spring are ignored.
  - If vel_next <= 0 -> FALL.
  - If (y_next>>FRAC) < SCROLL_LINE: y = SCROLL_LINE<<FRAC (fraction cleared), scroll_dy = SCROLL_LINE - (y_next>>FRAC), and scroll_valid=1 for exactly the cycle after the tick.
- FALL:
  - If land: y = (land_y - SPRITE_H - 1)<<FRAC; vel = spring ? BOOST_VEL : JUMP_VEL; go to RISE. Land takes priority over death in the same tick.
  - Else if (y_next>>FRAC) >= SCREEN_H: go to DEAD, set dead=1, freeze y.
- DEAD: y and vel frozen; dead held until game_state==0 or reset.
- game_state==2 while in RISE or FALL: motion frozen, state held.
- Sprite addressing (registered, 1-cycle latency from beam):
  - in_sprite = (x <= beam_x < x+SPRITE_W) && (y_int <= beam_y < y_int+SPRITE_H).
  - sprite_row = beam_y - y_int.
  - sprite_col = beam_x - x, or SPRITE_W-1-(beam_x-x) when MIRROR && facing_left.
  - When not in_sprite, row and col hold 0.
  - Position used is the registered value at the start of the cycle.

Test Plan:
- Reset then game_state=1 plus one tick -> RISE, y=687. Next tick -> doodle_y=678, vel=141, doodle_fall_direction=0.
- 48 ticks after takeoff, vel reaches 0 -> FALL, doodle_fall_direction=1. A land pulse with land_y=700 in the same tick -> y=619, RISE. With spring=1 -> vel=288.
- x=640, delta_x=+5 -> doodle_x=303. x=302, delta_x=-4 -> 640. delta_x=-1 -> facing_left=1; then delta_x=0 -> stays 1.
- Rising at y=305 with vel=144 -> y clamped to 300, scroll_dy=4, scroll_valid high exactly one cycle.
- Falling past y=768 with no land -> dead=1, y frozen. game_state=0 -> IDLE, x=472, y=687, dead=0. Asserting rst mid-fall clears everything asynchronously.
- x=472, y=687, facing_left=1, MIRROR=1, beam=(472,687) -> next cycle in_sprite=1, row=0, col=79. beam_x=552 -> in_sprite=0.
